// File: rtl/text_overlay_gen.sv
// rtl/text_overlay_gen.sv - on-screen text window renderer with host-written character buffer
//
// Purpose:
//   Holds a COLS x ROWS character buffer written by a host. The buffer is
//   rendered through a built-in 8x16 font ROM as a window at
//   (ORIGIN_X, ORIGIN_Y). Glyphs are scaled by 2^SCALE_LOG2. Each character
//   can blink, and the foreground and background colours come from the
//   switches. Inputs reach rgb_text/text_on four clocks later.
//
// Ports:
//   clk        pixel clock
//   reset      synchronous, active-high
//   video_on   visible-area flag from the sync generator
//   pixel_x    current pixel column (10 bits)
//   pixel_y    current pixel row (10 bits)
//   frame_tick one-cycle pulse per frame, advances the blink counter
//   wr_en      buffer write request, honoured only while wr_ready is high
//   wr_addr    buffer index = line*COLS + col
//   wr_char    7-bit character code
//   wr_blink   blink attribute for the written character
//   wr_ready   high once the post-reset buffer clear has finished
//   switch     [2:0] fg, [5:3] bg, [6] swap fg/bg, [7] blink enable
//   rgb_text   registered 3-bit colour
//   text_on    registered flag: pixel inside the window with video_on high

module text_overlay_gen #(
    parameter int COLS       = 8,
    parameter int ROWS       = 4,
    parameter int ORIGIN_X   = 0,
    parameter int ORIGIN_Y   = 0,
    parameter int SCALE_LOG2 = 0,
    parameter int BLINK_BITS = 5,
    localparam int N         = COLS * ROWS,
    localparam int AW        = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          video_on,
    input  logic [9:0]    pixel_x,
    input  logic [9:0]    pixel_y,
    input  logic          frame_tick,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [6:0]    wr_char,
    input  logic          wr_blink,
    output logic          wr_ready,
    input  logic [7:0]    switch,
    output logic [2:0]    rgb_text,
    output logic          text_on
);

    localparam int GLYPH_W = 8 << SCALE_LOG2;
    localparam int GLYPH_H = 16 << SCALE_LOG2;
    localparam int WIN_W   = COLS * GLYPH_W;
    localparam int WIN_H   = ROWS * GLYPH_H;

    // Glyph bitmaps. Row 0 is the most significant byte, and the MSB of
    // each byte is the leftmost pixel.
    localparam logic [127:0] GLYPH_0     = 128'h0000_7CC6_C6CE_DEF6_E6C6_C67C_0000_0000;
    localparam logic [127:0] GLYPH_1     = 128'h0000_1838_7818_1818_1818_187E_0000_0000;
    localparam logic [127:0] GLYPH_A     = 128'h0000_1038_6CC6_C6FE_C6C6_C6C6_0000_0000;
    localparam logic [127:0] GLYPH_B     = 128'h0000_FC66_6666_7C66_6666_66FC_0000_0000;
    localparam logic [127:0] GLYPH_C     = 128'h0000_3C66_C2C0_C0C0_C0C2_663C_0000_0000;
    localparam logic [127:0] GLYPH_SOLID = {128{1'b1}};

    function automatic logic [7:0] f_glyph_row(input logic [127:0] g, input logic [3:0] row);
        // ~row == 15-row selects the byte counted from the LSB end
        return g[{~row, 3'b000} +: 8];
    endfunction

    // Font ROM lookup. Codes without a bitmap render blank, like code 0x00.
    function automatic logic [7:0] f_font(input logic [6:0] code, input logic [3:0] row);
        logic [7:0] w;
        case (code)
            7'h30:   w = f_glyph_row(GLYPH_0, row);
            7'h31:   w = f_glyph_row(GLYPH_1, row);
            7'h41:   w = f_glyph_row(GLYPH_A, row);
            7'h42:   w = f_glyph_row(GLYPH_B, row);
            7'h43:   w = f_glyph_row(GLYPH_C, row);
            7'h7F:   w = f_glyph_row(GLYPH_SOLID, row);
            default: w = 8'h00;
        endcase
        return w;
    endfunction

    // ------------------------------------------------------------------
    // Control FSM: clear every entry after reset, then accept host writes
    // ------------------------------------------------------------------
    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t          r_state;
    logic [AW-1:0]   r_clr_addr;
    logic            r_wr_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= '0;
            r_wr_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (r_clr_addr == AW'(N - 1)) begin
                        r_state    <= ST_RUN;
                        r_wr_ready <= 1'b1;
                    end else begin
                        r_clr_addr <= r_clr_addr + 1'b1;
                    end
                end
                ST_RUN:   r_wr_ready <= 1'b1;
                default: begin
                    r_state    <= ST_CLEAR;
                    r_clr_addr <= '0;
                    r_wr_ready <= 1'b0;
                end
            endcase
        end
    end

    assign wr_ready = r_wr_ready;

    // ------------------------------------------------------------------
    // Character buffer {blink, code}: one write port, one synchronous read
    // ------------------------------------------------------------------
    logic [7:0] r_mem [N];
    logic       w_wr_fire;

    assign w_wr_fire = wr_en && r_wr_ready && ({{(32-AW){1'b0}}, wr_addr} < 32'(N));

    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_clr_addr] <= 8'h00;
        end else if (w_wr_fire) begin
            r_mem[wr_addr] <= {wr_blink, wr_char};
        end
    end

    // ------------------------------------------------------------------
    // Window geometry and addressing (10-bit unsigned)
    // ------------------------------------------------------------------
    logic [9:0]    w_dx, w_dy, w_col, w_line;
    logic          w_win;
    logic [AW-1:0] w_idx;
    logic [3:0]    w_row;
    logic [2:0]    w_bit;

    always_comb begin
        w_dx   = pixel_x - 10'(ORIGIN_X);
        w_dy   = pixel_y - 10'(ORIGIN_Y);
        w_win  = (pixel_x >= 10'(ORIGIN_X)) && (pixel_y >= 10'(ORIGIN_Y)) &&
                 ({22'b0, w_dx} < 32'(WIN_W)) && ({22'b0, w_dy} < 32'(WIN_H));
        w_col  = w_dx >> (3 + SCALE_LOG2);
        w_line = w_dy >> (4 + SCALE_LOG2);
        // Outside the window the index is parked at 0 so the read never
        // leaves the buffer; the result is masked by win downstream anyway.
        w_idx  = w_win ? (AW'(w_line) * AW'(COLS) + AW'(w_col)) : '0;
        w_row  = 4'(w_dy >> SCALE_LOG2);
        w_bit  = 3'(w_dx >> SCALE_LOG2);
    end

    // ------------------------------------------------------------------
    // Render pipeline: E1 geometry, E2 buffer, E3 font, E4 colour
    // ------------------------------------------------------------------
    logic          r1_vid, r1_win;
    logic [AW-1:0] r1_idx;
    logic [3:0]    r1_row;
    logic [2:0]    r1_bit;

    logic          r2_vid, r2_win;
    logic [7:0]    r2_data;
    logic [3:0]    r2_row;
    logic [2:0]    r2_bit;

    logic          r3_vid, r3_win, r3_blink;
    logic [7:0]    r3_font;
    logic [2:0]    r3_bit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r1_vid   <= 1'b0;
            r1_win   <= 1'b0;
            r1_idx   <= '0;
            r1_row   <= '0;
            r1_bit   <= '0;
            r2_vid   <= 1'b0;
            r2_win   <= 1'b0;
            r2_data  <= '0;
            r2_row   <= '0;
            r2_bit   <= '0;
            r3_vid   <= 1'b0;
            r3_win   <= 1'b0;
            r3_blink <= 1'b0;
            r3_font  <= '0;
            r3_bit   <= '0;
        end else begin
            r1_vid   <= video_on;
            r1_win   <= w_win;
            r1_idx   <= w_idx;
            r1_row   <= w_row;
            r1_bit   <= w_bit;

            r2_vid   <= r1_vid;
            r2_win   <= r1_win;
            r2_data  <= r_mem[r1_idx];
            r2_row   <= r1_row;
            r2_bit   <= r1_bit;

            r3_vid   <= r2_vid;
            r3_win   <= r2_win;
            r3_blink <= r2_data[7];
            r3_font  <= f_font(r2_data[6:0], r2_row);
            r3_bit   <= r2_bit;
        end
    end

    // ------------------------------------------------------------------
    // Blink counter
    // ------------------------------------------------------------------
    logic [BLINK_BITS-1:0] r_frame_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_cnt <= '0;
        end else if (frame_tick) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Colour stage; switch is used live here rather than pipelined
    // ------------------------------------------------------------------
    logic       w_font_bit, w_hide, w_lit, w_show;
    logic [2:0] w_fg, w_bg;

    always_comb begin
        // bit 0 is the leftmost pixel, which is the font word's MSB
        w_font_bit = r3_font[~r3_bit];
        w_hide     = switch[7] && r3_blink && r_frame_cnt[BLINK_BITS-1];
        w_lit      = w_font_bit && !w_hide;
        w_fg       = switch[6] ? switch[5:3] : switch[2:0];
        w_bg       = switch[6] ? switch[2:0] : switch[5:3];
        w_show     = r3_vid && r3_win;
    end

    always_ff @(posedge clk) begin
        if (reset || (r_state == ST_CLEAR)) begin
            rgb_text <= 3'b000;
            text_on  <= 1'b0;
        end else begin
            rgb_text <= w_show ? (w_lit ? w_fg : w_bg) : 3'b000;
            text_on  <= w_show;
        end
    end

endmodule
